// File: rtl/pulse_arb.sv
// Round-robin arbiter that time-shares one delayed, length-programmable pulse
// generator among N level requesters, with a guard gap after every pulse.
module pulse_arb #(
    parameter int N                = 4,
    parameter int MAX_LENGTH_TICKS = 100,
    parameter int DELAY_TICKS      = 100,
    parameter int GAP_TICKS        = 2,
    localparam int LW = $clog2(MAX_LENGTH_TICKS + 1),
    localparam int OW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*LW-1:0] len,
    output logic [N-1:0]    ack,
    output logic [N-1:0]    done,
    output logic            out,
    output logic            busy,
    output logic [OW-1:0]   owner
);

    localparam int CMAX_DL = (DELAY_TICKS > MAX_LENGTH_TICKS) ? DELAY_TICKS : MAX_LENGTH_TICKS;
    localparam int CMAX    = (GAP_TICKS > CMAX_DL) ? GAP_TICKS : CMAX_DL;
    localparam int CW      = $clog2(CMAX + 1);

    typedef enum logic [1:0] {IDLE, DELAY, PULSE, GAP} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  cnt_reg, cnt_next;
    logic [OW-1:0]  ptr_reg, ptr_next;
    logic [OW-1:0]  owner_reg, owner_next;
    logic [LW-1:0]  len_q_reg, len_q_next;
    logic [N-1:0]   ack_reg, ack_next;
    logic [N-1:0]   done_reg, done_next;
    logic           out_reg, out_next;
    logic           busy_reg, busy_next;

    logic [LW-1:0]  eff_len [N];
    logic           grant_valid;
    logic [OW-1:0]  grant_idx;
    logic [OW-1:0]  cand;

    // Per-requester length normalisation: 0 means 1, oversize clamps to max.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_len
            logic [LW-1:0] raw;
            assign raw = len[gi*LW +: LW];
            assign eff_len[gi] = (raw == '0) ? LW'(1) :
                                 (raw > LW'(MAX_LENGTH_TICKS)) ? LW'(MAX_LENGTH_TICKS) : raw;
        end
    endgenerate

    // Scan offsets from farthest to nearest so the first set bit after ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = N; k >= 1; k--) begin
            cand = OW'((int'(ptr_reg) + k) % N);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        len_q_next = len_q_reg;
        ack_next   = '0;
        done_next  = '0;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    ack_next   = N'(1) << grant_idx;
                    ptr_next   = grant_idx;
                    owner_next = grant_idx;
                    len_q_next = eff_len[grant_idx];
                    if (DELAY_TICKS == 0) begin
                        state_next = PULSE;
                        cnt_next   = CW'(eff_len[grant_idx]) - CW'(1);
                    end else begin
                        state_next = DELAY;
                        cnt_next   = CW'(DELAY_TICKS - 1);
                    end
                end
            end
            DELAY: begin
                if (cnt_reg == '0) begin
                    state_next = PULSE;
                    cnt_next   = CW'(len_q_reg) - CW'(1);
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_reg == '0) begin
                    done_next = N'(1) << owner_reg;
                    if (GAP_TICKS == 0) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = GAP;
                        cnt_next   = CW'(GAP_TICKS - 1);
                    end
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Registered outputs track the state being entered, so they align with it.
        out_next  = (state_next == PULSE);
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            ptr_reg   <= OW'(N - 1);
            owner_reg <= '0;
            len_q_reg <= '0;
            ack_reg   <= '0;
            done_reg  <= '0;
            out_reg   <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            len_q_reg <= len_q_next;
            ack_reg   <= ack_next;
            done_reg  <= done_next;
            out_reg   <= out_next;
            busy_reg  <= busy_next;
        end
    end

    assign ack   = ack_reg;
    assign done  = done_reg;
    assign out   = out_reg;
    assign busy  = busy_reg;
    assign owner = owner_reg;

endmodule

// File: tb/tb_pulse_arb.sv
// Directed bench for pulse_arb: a D=10/G=2 build and a D=0/G=0 build share clock and reset.
module tb_pulse_arb;

    localparam int N  = 4;
    localparam int LW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*LW-1:0] len = '0;
    logic [N-1:0]  ack, done;
    logic          out, busy;
    logic [1:0]    owner;

    logic [N-1:0]  zreq = '0;
    logic [N*LW-1:0] zlen = '0;
    logic [N-1:0]  zack, zdone;
    logic          zout, zbusy;
    logic [1:0]    zowner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pulse_arb #(.N(N), .MAX_LENGTH_TICKS(100), .DELAY_TICKS(10), .GAP_TICKS(2)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .ack(ack), .done(done),
        .out(out), .busy(busy), .owner(owner)
    );

    pulse_arb #(.N(N), .MAX_LENGTH_TICKS(100), .DELAY_TICKS(0), .GAP_TICKS(0)) dutz (
        .clk(clk), .rst(rst), .req(zreq), .len(zlen), .ack(zack), .done(zdone),
        .out(zout), .busy(zbusy), .owner(zowner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
        $display("check %-14s got=%0d want=%0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        zreq = '0;
        rst = 1'b1;
        repeat (5) step();
        rst = 1'b0;
    endtask

    task automatic wait_ack(output logic [N-1:0] a);
        a = '0;
        for (int i = 0; i < 500 && a == '0; i++) begin
            step();
            a = ack;
        end
        check("ack_seen", 32'(a != '0), 1);
    endtask

    task automatic wait_done(output logic [N-1:0] d);
        d = '0;
        for (int i = 0; i < 500 && d == '0; i++) begin
            step();
            d = done;
        end
        check("done_seen", 32'(d != '0), 1);
    endtask

    // Grants requester r with length l, returns the number of out-high cycles.
    task automatic measure(input int r, input int l, input bit change_len, output int n);
        logic [N-1:0] a;
        n = 0;
        len[r*LW +: LW] = LW'(l);
        req = N'(1) << r;
        wait_ack(a);
        req = '0;
        if (change_len) begin
            step();
            len[r*LW +: LW] = 7'd3;
        end
        for (int i = 0; i < 50 && !out; i++) step();
        while (out && n < 300) begin
            n++;
            step();
        end
        for (int i = 0; i < 10 && busy; i++) step();
    endtask

    initial begin
        logic [N-1:0] a, d;
        int n;
        int ng, np, nl, hi, lo;
        logic [N-1:0] order [8];
        int hi_len [8];
        int gaps [8];

        // Reset state
        do_reset();
        check("rst_ack", 32'(ack), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out", 32'(out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);

        // Single request, len 40: this cycle is T
        len[2*LW +: LW] = 7'd40;
        req = 4'b0100;
        step();
        check("s_ack", 32'(ack), 4);
        check("s_busy", 32'(busy), 1);
        check("s_owner", 32'(owner), 2);
        check("s_out_t1", 32'(out), 0);
        req = '0;
        repeat (9) step();
        check("s_out_t10", 32'(out), 0);
        step();
        check("s_out_t11", 32'(out), 1);
        repeat (39) step();
        check("s_out_t50", 32'(out), 1);
        check("s_done_t50", 32'(done), 0);
        step();
        check("s_out_t51", 32'(out), 0);
        check("s_done_t51", 32'(done), 4);
        step();
        check("s_busy_t52", 32'(busy), 1);
        step();
        check("s_busy_t53", 32'(busy), 0);

        // Contention: everyone requests, each drops after its ack
        do_reset();
        for (int i = 0; i < N; i++) len[i*LW +: LW] = 7'd5;
        req = 4'b1111;
        ng = 0; np = 0; nl = 0; hi = 0; lo = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (ack != '0 && ng < 8) begin
                order[ng] = ack;
                ng++;
                req = req & ~ack;
            end
            if (out) begin
                if (lo > 0 && np > 0 && nl < 8) begin
                    gaps[nl] = lo;
                    nl++;
                end
                lo = 0;
                hi++;
            end else begin
                if (hi > 0 && np < 8) begin
                    hi_len[np] = hi;
                    np++;
                end
                hi = 0;
                lo++;
            end
        end
        check("c_grants", 32'(ng), 4);
        check("c_pulses", 32'(np), 4);
        for (int k = 0; k < 4 && k < ng; k++) check("c_order", 32'(order[k]), 32'(1) << k);
        for (int k = 0; k < 4 && k < np; k++) check("c_len", 32'(hi_len[k]), 5);
        // Low cycles between pulses: gap + the idle grant cycle + delay
        for (int k = 0; k < 3 && k < nl; k++) check("c_gap", 32'(gaps[k]), 13);

        // Round-robin fairness: 1 re-requests after done while 3 waits
        do_reset();
        len[1*LW +: LW] = 7'd2;
        len[3*LW +: LW] = 7'd2;
        req = 4'b1010;
        wait_ack(a);
        check("f_ack1", 32'(a), 2);
        req[1] = 1'b0;
        wait_done(d);
        check("f_done1", 32'(d), 2);
        req[1] = 1'b1;
        wait_ack(a);
        check("f_ack3", 32'(a), 8);
        req[3] = 1'b0;
        wait_ack(a);
        check("f_ack1b", 32'(a), 2);
        req = '0;
        wait_done(d);

        // Length edge cases
        do_reset();
        measure(0, 0, 1'b0, n);
        check("l_len0", 32'(n), 1);
        measure(1, 100, 1'b0, n);
        check("l_len100", 32'(n), 100);
        measure(2, 127, 1'b0, n);
        check("l_len127", 32'(n), 100);
        measure(3, 20, 1'b1, n);
        check("l_latched", 32'(n), 20);

        // Reset in pulse cycle 20 of 40; 0 and 2 pending
        do_reset();
        len[1*LW +: LW] = 7'd40;
        req = 4'b0010;
        wait_ack(a);
        check("r_ack1", 32'(a), 2);
        len[0*LW +: LW] = 7'd8;
        len[2*LW +: LW] = 7'd8;
        req = 4'b0101;
        for (int i = 0; i < 50 && !out; i++) step();
        check("r_in_pulse", 32'(out), 1);
        repeat (19) step();
        rst = 1'b1;
        step();
        check("r_out_drop", 32'(out), 0);
        check("r_no_done", 32'(done), 0);
        check("r_busy", 32'(busy), 0);
        repeat (4) step();
        rst = 1'b0;
        step();
        check("r_ack0", 32'(ack), 1);
        req = '0;
        repeat (9) step();
        check("r_out_t10", 32'(out), 0);
        step();
        check("r_out_t11", 32'(out), 1);
        repeat (7) step();
        check("r_out_t18", 32'(out), 1);
        step();
        check("r_done_t19", 32'(done), 1);
        check("r_out_t19", 32'(out), 0);

        // Zero-delay, zero-gap build, back-to-back len 1
        do_reset();
        zlen[0*LW +: LW] = 7'd1;
        zlen[1*LW +: LW] = 7'd1;
        zreq = 4'b0001;
        step();
        check("z_ack_t1", 32'(zack), 1);
        check("z_out_t1", 32'(zout), 1);
        zreq = 4'b0010;
        step();
        check("z_done_t2", 32'(zdone), 1);
        check("z_out_t2", 32'(zout), 0);
        check("z_ack_t2", 32'(zack), 0);
        step();
        check("z_ack_t3", 32'(zack), 2);
        check("z_out_t3", 32'(zout), 1);
        zreq = '0;
        step();
        check("z_done_t4", 32'(zdone), 2);
        check("z_out_t4", 32'(zout), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
